// File: rtl/add_ca_ripple.sv
// add_ca_ripple: WIDTH-bit registered ripple-carry adder, {cout,q} = a + b + cin
//   clk    in  1      rising-edge clock
//   rst_n  in  1      asynchronous active-low reset, clears all outputs
//   a, b   in  WIDTH  unsigned addends
//   cin    in  1      carry into bit 0
//   q      out WIDTH  registered sum
//   cout   out 1      registered carry out of the MSB
//   ovf    out 1      registered two's-complement overflow, only with ADDCA_OVF_EN
module add_ca_ripple #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] q,
  output logic             cout
`ifdef ADDCA_OVF_EN
  ,
  output logic             ovf
`endif
);
  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] r_q;
  logic             r_cout;
  assign w_c[0] = cin;
  // Carry ripples LSB to MSB through one full-adder cell per bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign w_s[i]   = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_q    <= '0;
      r_cout <= 1'b0;
    end else begin
      r_q    <= w_s;
      r_cout <= w_c[WIDTH];
    end
  assign q    = r_q;
  assign cout = r_cout;
`ifdef ADDCA_OVF_EN
  logic r_ovf;
  // Signed overflow: carry into the sign bit differs from carry out of it.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_ovf <= 1'b0;
    else        r_ovf <= w_c[WIDTH] ^ w_c[WIDTH-1];
  assign ovf = r_ovf;
`endif
endmodule

// File: tb/tb_add_ca_ripple.sv
// tb_add_ca_ripple: table, directed reset sequences and random sweep for add_ca_ripple
module tb_add_ca_ripple;
  localparam int W = 4;
  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic [W-1:0] q;
  logic         cout;
`ifdef ADDCA_OVF_EN
  logic         ovf;
`endif
  int n_pass = 0;
  int n_tot = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] q;
    logic         co;
    logic         ov;
  } vec_t;

  typedef struct {
    string        name;
    logic [W-1:0] q;
    logic         co;
    logic         ov;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[10];

  add_ca_ripple #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .q    (q),
    .cout (cout)
`ifdef ADDCA_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic compare();
    exp_t e;
    if (sb.size() == 0) begin
      n_tot++;
      $display("FAIL sb_empty: got no expectation required one");
      return;
    end
    e = sb.pop_front();
    chk({e.name, "_q"}, 64'(q), 64'(e.q));
    chk({e.name, "_cout"}, 64'(cout), 64'(e.co));
`ifdef ADDCA_OVF_EN
    chk({e.name, "_ovf"}, 64'(ovf), 64'(e.ov));
`endif
  endtask

  task automatic drive(input string nm, input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic vc, input logic [W-1:0] eq, input logic eco, input logic eov);
    exp_t e;
    @(negedge clk);
    a = va;
    b = vb;
    cin = vc;
    e.name = nm;
    e.q = eq;
    e.co = eco;
    e.ov = eov;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic model(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                       output logic [W-1:0] eq, output logic eco, output logic eov);
    int s, sa, sb_s, ss;
    s = int'(va) + int'(vb) + int'(vc);
    eq = W'(s % (1 << W));
    eco = (s >= (1 << W));
    sa = (int'(va) >= (1 << (W-1))) ? int'(va) - (1 << W) : int'(va);
    sb_s = (int'(vb) >= (1 << (W-1))) ? int'(vb) - (1 << W) : int'(vb);
    ss = sa + sb_s + int'(vc);
    eov = (ss > (1 << (W-1)) - 1) || (ss < -(1 << (W-1)));
  endtask

  initial begin
    logic [W-1:0] ra, rb, eq;
    logic rc, eco, eov;
    tbl[0] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};
    tbl[1] = '{4'h5, 4'hA, 1'b0, 4'hF, 1'b0, 1'b0};
    tbl[2] = '{4'h7, 4'hA, 1'b0, 4'h1, 1'b1, 1'b0};
    tbl[3] = '{4'h1, 4'hF, 1'b0, 4'h0, 1'b1, 1'b0};
    tbl[4] = '{4'h1, 4'hF, 1'b1, 4'h1, 1'b1, 1'b0};
    tbl[5] = '{4'hF, 4'hF, 1'b0, 4'hE, 1'b1, 1'b0};
    tbl[6] = '{4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1};
    tbl[7] = '{4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0};
    tbl[8] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0};
    tbl[9] = '{4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1};

    a = 4'h9;
    b = 4'h6;
    cin = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("init_rst_q", 64'(q), 64'h0);
    chk("init_rst_cout", 64'(cout), 64'h0);
    #4;
    chk("init_rst_hold_q", 64'(q), 64'h0);
    a = 4'h0;
    b = 4'h0;
    cin = 1'b0;
    #1 rst_n = 1'b1;

    foreach (tbl[i])
      drive($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].q, tbl[i].co, tbl[i].ov);

    drive("preload", 4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0);
    @(negedge clk);
    a = 4'h3;
    b = 4'h4;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_q", 64'(q), 64'h0);
    chk("mid_rst_cout", 64'(cout), 64'h0);
    @(posedge clk);
    #1;
    chk("mid_rst_hold_q", 64'(q), 64'h0);
    #2;
    a = 4'h2;
    b = 4'h5;
    cin = 1'b1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("release_load_q", 64'(q), 64'h8);
    chk("release_load_cout", 64'(cout), 64'h0);

    for (int i = 0; i < 200; i++) begin
      ra = W'($urandom_range(0, (1 << W) - 1));
      rb = W'($urandom_range(0, (1 << W) - 1));
      rc = 1'($urandom_range(0, 1));
      model(ra, rb, rc, eq, eco, eov);
      drive($sformatf("rnd%0d", i), ra, rb, rc, eq, eco, eov);
    end

    if (sb.size() != 0) begin
      n_tot++;
      $display("FAIL sb_leftover: got %0d entries required 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
